sub_seq: RTL
============

Name: sub_seq

Overview:
- Multi-cycle, chunk-serial subtractor. Computes diff = a - b - borrow_in over WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle, LSB slice first.
- Uses valid/ready handshakes on both input and output sides.
- It is the inverse-operation companion of the registered 32-bit adder datapath. It targets area-constrained paths that tolerate latency in exchange for a narrow subtract cell.

Parameters:
WIDTH, 32, operand and result width in bits
CHUNK, 8, bits processed per cycle; must divide WIDTH exactly, otherwise elaboration fails with a fatal error; CHUNK==WIDTH is legal

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  operands valid
ready_o  output  1  block can accept operands
a_i  input  WIDTH  minuend
b_i  input  WIDTH  subtrahend
borrow_i  input  1  borrow in
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
diff_o  output  WIDTH  a - b - borrow_i, modulo 2^WIDTH
borrow_o  output  1  unsigned borrow out (1 when a < b + borrow_i)
overflow_o  output  1  signed two's-complement overflow

Behaviour:
- NCHUNK = WIDTH/CHUNK. Internal slice counter width = max(1, clog2(NCHUNK)).
- States: IDLE, CALC, DONE.
- Reset (rst_ni low, asynchronous):
  - state=IDLE, counter=0, operand/result/borrow registers=0.
  - valid_o=0, diff_o=0, borrow_o=0, overflow_o=0.
- ready_o = (state==IDLE), decoded combinationally from the state register. It is therefore 1 during reset.
- IDLE:
  - On a rising edge with valid_i && ready_o: capture a_i, b_i, borrow_i into internal registers, counter=0, result register cleared, state->CALC.
  - Without valid_i: remain in IDLE.
- CALC, each cycle for slice k = counter:
  - {bo, d} = a[k*CHUNK +: CHUNK] - b[k*CHUNK +: CHUNK] - running_borrow.
  - d is written into the result register at slice k. running_borrow = bo. counter++.
  - After slice NCHUNK-1 completes: state->DONE.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), registered together with the final slice.
- Latency: if operands are accepted at edge E0, valid_o is 1 immediately after edge E0+NCHUNK (default 4 edges).
  - ready_o is 0 from E0 until the output handshake.
  - valid_i and operand inputs are ignored during CALC and DONE.
- DONE:
  - valid_o=1. diff_o, borrow_o, overflow_o are stable and hold while ready_i is 0, for any length of backpressure.
  - On an edge with ready_i=1: state->IDLE, valid_o=0.
  - No new operands are accepted in the same edge; the next accept is possible at the following edge at the earliest.
  - Minimum throughput: one operation per NCHUNK+2 cycles.
- diff_o, borrow_o, overflow_o are defined only while valid_o=1. During CALC they may show partial values.
- ready_i is ignored outside DONE.
- Reset asserted mid-CALC or mid-DONE: the operation is aborted immediately and the pending result is lost. Outputs go to reset values. The first accept is possible at the first edge after rst_ni rises.
- No saturation: arithmetic wraps modulo 2^WIDTH.

Test Plan:
1. Reset, then a=0x00000005, b=0x00000003, borrow_i=0, ready_i=1 -> exactly 4 edges after accept: valid_o=1, diff_o=0x00000002, borrow_o=0, overflow_o=0; ready_o=1 one edge later.
2. a=0x00000000, b=0x00000001, borrow_i=0 -> diff_o=0xFFFFFFFF, borrow_o=1, overflow_o=0 (borrow ripples across all 4 slices). Also a=0x00000100, b=0x00000001 -> diff_o=0x000000FF, borrow_o=0.
3. a=0x80000000, b=0x00000000, borrow_i=1 -> diff_o=0x7FFFFFFF, borrow_o=0, overflow_o=1. Also a=0x00000000, b=0x7FFFFFFF, borrow_i=1 -> diff_o=0x80000000, borrow_o=1, overflow_o=0.
4. Backpressure: hold ready_i=0 for 6 cycles in DONE while toggling valid_i and a_i -> valid_o and the result stay constant and ready_o stays 0. Then raise ready_i -> valid_o=0 and ready_o=1 after that edge; the ignored operands never produce a result.
5. Reset mid-operation: assert rst_ni=0 asynchronously after 2 CALC slices -> valid_o=0 and all outputs 0 without waiting for a clock edge. After release, a=0x12345678, b=0x11111111 -> diff_o=0x01234567, borrow_o=0.
6. Back-to-back with valid_i held high and ready_i=1 -> accepts spaced exactly NCHUNK+2 cycles apart. Repeat with CHUNK=32 (valid_o one edge after accept) and CHUNK=4 (8 edges).

Source files
------------

// File: rtl/sub_seq.sv
`timescale 1ns/1ps
// sub_seq: chunk-serial subtractor.
// Computes diff = a - b - borrow_in one CHUNK-bit slice per clock, LSB slice
// first, with valid/ready handshakes on the operand and result sides.
// The narrow subtract cell is reused WIDTH/CHUNK times per operation.
module sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NCHUNK - 1);

  // A slice width that does not tile the operand cannot be sequenced.
  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $fatal(1, "sub_seq: CHUNK must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             borrow_reg, borrow_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             ovf_reg, ovf_next;

  // Operand slices, viewed as arrays so the active one is picked by counter.
  logic [CHUNK-1:0] a_slice [NCHUNK];
  logic [CHUNK-1:0] b_slice [NCHUNK];
  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic [CHUNK:0]   slice_sub;
  logic             slice_last;

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Select the operand slices addressed by the slice counter.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_reg == CNT_W'(k)) begin
        a_cur = a_slice[k];
        b_cur = b_slice[k];
      end
    end
  end

  // One narrow subtract cell; the extra top bit is the slice borrow-out.
  assign slice_sub  = {1'b0, a_cur} - {1'b0, b_cur} - {{CHUNK{1'b0}}, borrow_reg};
  assign slice_last = (cnt_reg == LAST_SLICE);

  // State and datapath registers; reset clears every result bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      diff_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      borrow_reg <= borrow_next;
      diff_reg   <= diff_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Next-state and datapath update: accept, ripple slices, hold result.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    borrow_next = borrow_reg;
    diff_next   = diff_reg;
    ovf_next    = ovf_reg;
    unique case (state_reg)
      IDLE: begin
        if (valid_i) begin
          a_next      = a_i;
          b_next      = b_i;
          borrow_next = borrow_i;
          cnt_next    = '0;
          diff_next   = '0;
          ovf_next    = 1'b0;
          state_next  = CALC;
        end
      end
      CALC: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_reg == CNT_W'(k)) begin
            diff_next[k*CHUNK +: CHUNK] = slice_sub[CHUNK-1:0];
          end
        end
        borrow_next = slice_sub[CHUNK];
        if (slice_last) begin
          // The top bit of the last slice is the result sign bit.
          ovf_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                       (slice_sub[CHUNK-1] != a_reg[WIDTH-1]);
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready_o    = (state_reg == IDLE);
  assign valid_o    = (state_reg == DONE);
  assign diff_o     = diff_reg;
  assign borrow_o   = borrow_reg;
  assign overflow_o = ovf_reg;

endmodule
